// File: rtl/matrix_pkg.sv
// Shared types for the matrix operation front end: operation codes, sequencer
// states and the register-number width used by the decoder and sequencer.
package matrix_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    OP_ADD       = 2'd0,
    OP_SUB       = 2'd1,
    OP_MUL       = 2'd2,
    OP_TRANSPOSE = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_A    = 3'd1,
    S_GET_B    = 3'd2,
    S_GET_DEST = 3'd3,
    S_ISSUE    = 3'd4
  } opseq_state_t;

  function automatic logic is_unary(input op_t op);
    return (op == OP_TRANSPOSE);
  endfunction

endpackage

// File: rtl/opseq_timeout.sv
// Idle-cycle watchdog for operand collection; only built with OPSEQ_TIMEOUT_EN.
// expired asserts on the TIMEOUT_CYCLES-th consecutive enabled cycle without a clear.
`ifdef OPSEQ_TIMEOUT_EN
module opseq_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == LAST);

endmodule
`endif

// File: rtl/operand_sequencer.sv
// Collects source/destination register selections for one matrix op and offers
// them to the datapath with valid/ready. Optional abort watchdog: OPSEQ_TIMEOUT_EN.
module operand_sequencer
  import matrix_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = matrix_pkg::REG_W
`ifdef OPSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             is_reg,
  input  logic [REG_W-1:0] reg_num,
  input  logic             op_start,
  input  logic [1:0]       op_code,
  input  logic             cancel,
  input  logic             op_ready,
  output logic             op_valid,
  output logic [1:0]       op_out,
  output logic [REG_W-1:0] src_a,
  output logic [REG_W-1:0] src_b,
  output logic [REG_W-1:0] dest,
  output logic             busy,
  output logic             sel_err
);

  localparam logic [REG_W-1:0] MAX_REG = REG_W'(NUM_REGS);

  opseq_state_t     state_q, state_d;
  op_t              op_out_q, op_out_d;
  logic [REG_W-1:0] src_a_q, src_a_d;
  logic [REG_W-1:0] src_b_q, src_b_d;
  logic [REG_W-1:0] dest_q, dest_d;
  logic             op_valid_q, op_valid_d;
  logic             busy_q, busy_d;
  logic             sel_err_q, sel_err_d;
  logic             is_reg_d_q;

  logic sel;
  logic sel_ok;
  logic collecting;

  // The decoder presents reg_num one cycle after its is_reg pulse.
  assign sel        = is_reg_d_q;
  assign sel_ok     = sel && (reg_num != '0) && (reg_num <= MAX_REG);
  assign collecting = (state_q == S_GET_A) || (state_q == S_GET_B) ||
                      (state_q == S_GET_DEST);

`ifdef OPSEQ_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_expired;

  assign tmo_clear = sel || ((state_q == S_IDLE) && (state_d == S_GET_A));

  opseq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (tmo_clear),
    .enable (collecting),
    .expired(tmo_expired)
  );
`endif

  always_comb begin
    state_d   = state_q;
    op_out_d  = op_out_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    dest_d    = dest_q;
    sel_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (op_start && !cancel) begin
          op_out_d = op_t'(op_code);
          src_a_d  = '0;
          src_b_d  = '0;
          dest_d   = '0;
          state_d  = S_GET_A;
        end
      end
      S_GET_A: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (sel_ok) begin
          src_a_d = reg_num;
          state_d = is_unary(op_out_q) ? S_GET_DEST : S_GET_B;
        end else if (sel) begin
          sel_err_d = 1'b1;
        end
      end
      S_GET_B: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (sel_ok) begin
          src_b_d = reg_num;
          state_d = S_GET_DEST;
        end else if (sel) begin
          sel_err_d = 1'b1;
        end
      end
      S_GET_DEST: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (sel_ok) begin
          dest_d  = reg_num;
          state_d = S_ISSUE;
        end else if (sel) begin
          sel_err_d = 1'b1;
        end
      end
      // The request has been offered; cancel cannot withdraw it.
      S_ISSUE: begin
        if (op_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef OPSEQ_TIMEOUT_EN
    if (collecting && !cancel && !sel && tmo_expired) begin
      state_d   = S_IDLE;
      sel_err_d = 1'b1;
    end
`endif

    op_valid_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      op_out_q   <= OP_ADD;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dest_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sel_err_q  <= 1'b0;
      is_reg_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_out_q   <= op_out_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      dest_q     <= dest_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      sel_err_q  <= sel_err_d;
      is_reg_d_q <= is_reg;
    end
  end

  assign op_valid = op_valid_q;
  assign op_out   = op_out_q;
  assign src_a    = src_a_q;
  assign src_b    = src_b_q;
  assign dest     = dest_q;
  assign busy     = busy_q;
  assign sel_err  = sel_err_q;

endmodule
